if_prefetch_buf: RTL

Parametrised instruction-fetch stage with a prefetch buffer. It sits between the PC/ROM interface and the if_id pipeline register. It issues sequential fetch addresses to a fixed-latency synchronous instruction ROM and tracks requests in flight. Returned instructions are buffered in a FIFO so that a hold (stall) from downstream never loses an instruction. A jump flushes everything in flight and redirects fetch.

---
 rtl/if_pkg.sv | 17 +
 rtl/if_fifo.sv | 64 ++++++
 rtl/if_prefetch_buf.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch prefetch stage.
package if_pkg;

  localparam int unsigned IF_ADDR_W = 32;
  localparam int unsigned IF_INST_W = 32;

  // Canonical no-op (addi x0, x0, 0) shown while no real instruction is available.
  localparam logic [IF_INST_W-1:0] INST_NOP      = 32'h0000_0013;
  localparam logic [IF_ADDR_W-1:0] IF_RESET_ADDR = 32'h0000_0000;

  // One buffered fetch result, address in the upper field.
  typedef struct packed {
    logic [IF_ADDR_W-1:0] addr;
    logic [IF_INST_W-1:0] inst;
  } if_entry_t;

endpackage : if_pkg

// File: rtl/if_fifo.sv
// Single-clock FIFO holding fetched {addr, inst} entries; flush overrides push/pop.
module if_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; contents are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && full))  else $error("if_fifo: push while full ignored");
      assert (!(pop && empty))  else $error("if_fifo: pop while empty ignored");
    end
  end

endmodule : if_fifo

// File: rtl/if_prefetch_buf.sv
// Fetch stage: credit-limited sequential ROM fetch with a hold-tolerant prefetch FIFO.
// Optional macro IF_BYPASS_EN lets a return load the output register directly when the FIFO is idle.
module if_prefetch_buf
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W     = IF_ADDR_W,
  parameter int unsigned       INST_W     = IF_INST_W,
  parameter int unsigned       ROM_LAT    = 2,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(IF_RESET_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_flag_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o
);

  localparam int unsigned EW = ADDR_W + INST_W;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = $clog2(ROM_LAT + 1);
  localparam int unsigned SW = CW + IW;
  localparam logic [INST_W-1:0] NOP = INST_W'(INST_NOP);

  logic [ADDR_W-1:0]  pc_q;
  logic [ROM_LAT-1:0] pipe_vld_q;
  logic [ADDR_W-1:0]  pipe_addr_q [ROM_LAT];
  logic [IW-1:0]      inflight;
  logic               issue;

  logic               tail_vld;
  logic [ADDR_W-1:0]  tail_addr;
  logic               bypass;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [EW-1:0]      fifo_wdata;
  logic [EW-1:0]      fifo_rdata;

  logic [INST_W-1:0]  inst_q;
  logic [INST_W-1:0]  inst_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_d;
  logic               valid_q;
  logic               valid_d;

  assign rom_addr_o = pc_q;

  // Requests in flight: every valid tracking stage owns a future FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(ROM_LAT); i++) begin
      inflight = inflight + IW'(pipe_vld_q[i]);
    end
  end

  assign issue = ((SW'(inflight) + SW'(fifo_count)) < SW'(DEPTH)) && !jump_en_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              pc_q <= RESET_ADDR;
    else if (jump_en_i)   pc_q <= jump_addr_i;
    else if (issue)       pc_q <= pc_q + ADDR_W'(4);
  end

  // Tracking pipe valid bits mirror the ROM latency; a jump kills every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
    end else if (jump_en_i) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= issue;
      for (int i = 1; i < int'(ROM_LAT); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
    end
  end

  // Address side of the tracking pipe needs no reset; it is qualified by the valid bits.
  always_ff @(posedge clk) begin
    pipe_addr_q[0] <= pc_q;
    for (int i = 1; i < int'(ROM_LAT); i++) begin
      pipe_addr_q[i] <= pipe_addr_q[i-1];
    end
  end

  assign tail_vld  = pipe_vld_q[ROM_LAT-1];
  assign tail_addr = pipe_addr_q[ROM_LAT-1];

`ifdef IF_BYPASS_EN
  assign bypass = tail_vld && fifo_empty && !hold_flag_i && !jump_en_i;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push  = tail_vld && !bypass && !jump_en_i;
  assign fifo_pop   = !hold_flag_i && !fifo_empty && !jump_en_i;
  assign fifo_wdata = {tail_addr, rom_inst_i};

  if_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (jump_en_i),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output register next value: jump clears, hold freezes, otherwise head (or bypass) or a bubble.
  always_comb begin
    inst_d  = inst_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    if (jump_en_i) begin
      inst_d  = NOP;
      addr_d  = '0;
      valid_d = 1'b0;
    end else if (!hold_flag_i) begin
      if (!fifo_empty) begin
        inst_d  = fifo_rdata[INST_W-1:0];
        addr_d  = fifo_rdata[EW-1:INST_W];
        valid_d = 1'b1;
      end else if (bypass) begin
        inst_d  = rom_inst_i;
        addr_d  = tail_addr;
        valid_d = 1'b1;
      end else begin
        inst_d  = NOP;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= NOP;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_addr_o  = addr_q;
  assign inst_valid_o = valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_push && fifo_full))
        else $error("if_prefetch_buf: ROM return with prefetch buffer full");
      assert (!jump_en_i || (jump_addr_i[1:0] == 2'b00))
        else $error("if_prefetch_buf: unaligned jump target");
    end
  end

endmodule : if_prefetch_buf
